// File: rtl/efi_cfg_pkg.sv
// Shared EFI configuration definitions: register index map, power-on
// defaults for the configuration bank, and the commit controller state type.
package efi_cfg_pkg;

  localparam int unsigned CFG_NREGS = 16;

  // Register index map
  localparam int unsigned CFG_MODE          = 0;
  localparam int unsigned CFG_TOOTH_CNT     = 1;
  localparam int unsigned CFG_SYNC_FILT     = 2;
  localparam int unsigned CFG_MISSING_TEETH = 3;
  localparam int unsigned CFG_TDC_OFFSET    = 4;
  localparam int unsigned CFG_RPM_LIMIT     = 5;
  localparam int unsigned CFG_IGN_ADV       = 6;
  localparam int unsigned CFG_DWELL_US      = 7;
  localparam int unsigned CFG_DWELL_MAX_US  = 8;
  localparam int unsigned CFG_INJ_OFFSET    = 9;
  localparam int unsigned CFG_INJ_A_DEAD    = 10;
  localparam int unsigned CFG_INJ_B_DEAD    = 11;
  localparam int unsigned CFG_PRIME_PW      = 12;
  localparam int unsigned CFG_IGN_TRIM      = 13;
  localparam int unsigned CFG_INJ_A_PW      = 14;
  localparam int unsigned CFG_INJ_B_PW      = 15;

  localparam logic [15:0] CFG_DEFAULT [CFG_NREGS] = '{
    16'h0037, 16'd60,   16'd128,  16'd2,
    16'd0,    16'd7680, 16'd0,    16'd2560,
    16'd5120, 16'd0,    16'd342,  16'd342,
    16'd2000, 16'd0,    16'd0,    16'd0
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_COMMIT
  } cfg_state_t;

  // Default value for register idx; registers beyond the table reset to zero.
  function automatic logic [15:0] cfg_default(input int unsigned idx);
    return (idx < CFG_NREGS) ? CFG_DEFAULT[idx] : 16'h0000;
  endfunction

endpackage

// File: rtl/cfg_commit_ctrl_if.sv
// Host-side configuration bus: shadow write port plus commit/abort requests.
//   wr_en/wr_addr/wr_data : one shadow register write per cycle
//   commit_req            : pulse, request shadow -> active copy
//   abort_req             : pulse, cancel a pending commit
// master = register file side (drives), slave = commit controller (receives).
interface cfg_commit_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 16
) ();
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          commit_req;
  logic          abort_req;

  modport master (output wr_en, wr_addr, wr_data, commit_req, abort_req);
  modport slave  (input  wr_en, wr_addr, wr_data, commit_req, abort_req);
endinterface

// File: rtl/cfg_shadow_bank.sv
// Shadow/active configuration register bank.
//   clk, reset          : EFI clock, synchronous active-high reset
//   wr_en/addr/data     : shadow write; out-of-range addresses ignored
//   copy                : active <= shadow for every register, dirty cleared
//   cfg_active          : active bank, reg i at [i*DW +: DW]
//   dirty               : per-register pending-write flags
module cfg_shadow_bank
  import efi_cfg_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  input  logic                copy,
  output logic [NREGS*DW-1:0] cfg_active,
  output logic [NREGS-1:0]    dirty
);

  logic [DW-1:0] shadow [NREGS];
  logic [DW-1:0] active [NREGS];
  logic          wr_hit;

  assign wr_hit = wr_en && (32'(wr_addr) < 32'(NREGS));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        shadow[i] <= DW'(cfg_default(i));
        active[i] <= DW'(cfg_default(i));
      end
      dirty <= '0;
    end else begin
      if (copy) begin
        for (int unsigned i = 0; i < NREGS; i++) begin
          active[i] <= shadow[i];
        end
        dirty <= '0;
      end
      // A write landing on the copy edge is forwarded into the active bank
      // (overriding the stale shadow value copied above) and stays clean.
      if (wr_hit) begin
        shadow[wr_addr] <= wr_data;
        if (copy) begin
          active[wr_addr] <= wr_data;
        end else begin
          dirty[wr_addr] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign cfg_active[g*DW +: DW] = active[g];
  end

endmodule

// File: rtl/cfg_commit_ctrl.sv
// Atomic configuration-commit controller between the SPI register file and
// the EFI datapath. Host writes go to a shadow bank; a commit request copies
// the whole bank to the active bank at a safe engine point (trigger pulse,
// immediately when not synced, or forced after TIMEOUT_CYC armed cycles).
//   clk, reset     : EFI clock, synchronous active-high reset
//   host           : shadow write port and commit/abort requests
//   synced         : engine sync status
//   trigger        : one-cycle safe-point pulse
//   cfg_active     : active bank, flattened, reg i at [i*DW +: DW]
//   dirty          : per-register pending-write flags
//   busy           : controller not idle
//   commit_done    : pulse, new cfg_active visible this cycle
//   commit_forced  : pulse with commit_done when the commit timed out
//   commit_count   : completed commits, wraps at 256
module cfg_commit_ctrl
  import efi_cfg_pkg::*;
#(
  parameter int          NREGS       = 16,
  parameter int          AW          = 4,
  parameter int          DW          = 16,
  parameter logic [31:0] TIMEOUT_CYC = 32'd2000000
) (
  input  logic                clk,
  input  logic                reset,
  cfg_commit_ctrl_if.slave    host,
  input  logic                synced,
  input  logic                trigger,
  output logic [NREGS*DW-1:0] cfg_active,
  output logic [NREGS-1:0]    dirty,
  output logic                busy,
  output logic                commit_done,
  output logic                commit_forced,
  output logic [7:0]          commit_count
);

  cfg_state_t  state, state_nxt;
  logic [31:0] timer, timer_nxt;
  logic        force_q, force_nxt;
  logic        empty_commit;
  logic        in_commit;

  assign in_commit = (state == ST_COMMIT);
  assign busy      = (state != ST_IDLE);

  cfg_shadow_bank #(
    .NREGS (NREGS),
    .AW    (AW),
    .DW    (DW)
  ) u_bank (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (host.wr_en),
    .wr_addr    (host.wr_addr),
    .wr_data    (host.wr_data),
    .copy       (in_commit),
    .cfg_active (cfg_active),
    .dirty      (dirty)
  );

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    force_nxt    = force_q;
    empty_commit = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (host.commit_req) begin
          if (|dirty) begin
            state_nxt = ST_ARMED;
            timer_nxt = '0;
            force_nxt = 1'b0;
          end else begin
            empty_commit = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (host.abort_req) begin
          state_nxt = ST_IDLE;
        end else if (!synced || trigger) begin
          state_nxt = ST_COMMIT;
          force_nxt = 1'b0;
        end else if (timer == TIMEOUT_CYC - 32'd1) begin
          state_nxt = ST_COMMIT;
          force_nxt = 1'b1;
        end else begin
          timer_nxt = timer + 32'd1;
        end
      end
      ST_COMMIT: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      timer         <= '0;
      force_q       <= 1'b0;
      commit_done   <= 1'b0;
      commit_forced <= 1'b0;
      commit_count  <= '0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      force_q       <= force_nxt;
      commit_done   <= in_commit || empty_commit;
      commit_forced <= in_commit && force_q;
      if (in_commit) begin
        commit_count <= commit_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cfg_commit_ctrl.sv
module tb_cfg_commit_ctrl;

  localparam int          N      = 16;
  localparam logic [31:0] TO_BIG = 32'd2000000;
  localparam logic [31:0] TO_SML = 32'd8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic synced = 1'b1;
  logic trigger = 1'b0;

  always #5 clk = ~clk;

  cfg_commit_ctrl_if #(.AW(4), .DW(16)) bus ();

  logic [255:0] act0, act1;
  logic [15:0]  dirty0, dirty1;
  logic         busy0, busy1, done0, done1, forced0, forced1;
  logic [7:0]   cnt0, cnt1;

  cfg_commit_ctrl #(.NREGS(16), .AW(4), .DW(16), .TIMEOUT_CYC(TO_BIG)) dut0 (
    .clk(clk), .reset(reset), .host(bus), .synced(synced), .trigger(trigger),
    .cfg_active(act0), .dirty(dirty0), .busy(busy0), .commit_done(done0),
    .commit_forced(forced0), .commit_count(cnt0)
  );

  cfg_commit_ctrl #(.NREGS(16), .AW(4), .DW(16), .TIMEOUT_CYC(TO_SML)) dut1 (
    .clk(clk), .reset(reset), .host(bus), .synced(synced), .trigger(trigger),
    .cfg_active(act1), .dirty(dirty1), .busy(busy1), .commit_done(done1),
    .commit_forced(forced1), .commit_count(cnt1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per DUT: a commit is either not requested, pending (waiting for a safe
  // point, counting waited cycles), or scheduled to land on the next edge.
  bit [15:0]   defv [N] = '{16'h0037, 60, 128, 2, 0, 7680, 0, 2560,
                            5120, 0, 342, 342, 2000, 0, 0, 0};
  bit [15:0]   m_sh   [2][N];
  bit [15:0]   m_act  [2][N];
  bit [15:0]   m_dirty[2];
  bit          m_pend [2];
  bit          m_land [2];
  bit          m_flag [2];
  int unsigned m_wait [2];
  bit          m_done [2];
  bit          m_forced[2];
  bit [7:0]    m_cnt  [2];
  int unsigned m_to   [2] = '{32'd2000000, 32'd8};
  bit          model_ok = 1'b0;

  task automatic model_step(input int d);
    bit landing;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_sh[d][i]  = defv[i];
        m_act[d][i] = defv[i];
      end
      m_dirty[d] = '0; m_pend[d] = 0; m_land[d] = 0; m_flag[d] = 0;
      m_wait[d] = 0; m_done[d] = 0; m_forced[d] = 0; m_cnt[d] = 0;
      return;
    end
    landing     = m_land[d];
    m_done[d]   = landing || (!m_pend[d] && !landing && bus.commit_req && m_dirty[d] == 0);
    m_forced[d] = landing && m_flag[d];
    if (landing) begin
      for (int i = 0; i < N; i++) m_act[d][i] = m_sh[d][i];
      m_dirty[d] = '0;
      m_cnt[d]   = m_cnt[d] + 1;
      m_land[d]  = 0;
    end else if (m_pend[d]) begin
      if (bus.abort_req) m_pend[d] = 0;
      else if (!synced || trigger) begin
        m_pend[d] = 0; m_land[d] = 1; m_flag[d] = 0;
      end else if (m_wait[d] + 1 == m_to[d]) begin
        m_pend[d] = 0; m_land[d] = 1; m_flag[d] = 1;
      end else m_wait[d]++;
    end else if (bus.commit_req && m_dirty[d] != 0) begin
      m_pend[d] = 1;
      m_wait[d] = 0;
    end
    if (bus.wr_en) begin
      m_sh[d][bus.wr_addr] = bus.wr_data;
      if (landing) m_act[d][bus.wr_addr] = bus.wr_data;
      else m_dirty[d][bus.wr_addr] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    if (reset) model_ok <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int d = 0; d < 2; d++) begin
        logic [255:0] exp_act;
        for (int i = 0; i < N; i++) exp_act[i*16 +: 16] = m_act[d][i];
        chk($sformatf("cfg_active[%0d]", d), (d == 0) ? act0 : act1, exp_act);
        chk($sformatf("dirty[%0d]", d), 256'((d == 0) ? dirty0 : dirty1), 256'(m_dirty[d]));
        chk($sformatf("busy[%0d]", d), 256'((d == 0) ? busy0 : busy1), 256'(m_pend[d] || m_land[d]));
        chk($sformatf("commit_done[%0d]", d), 256'((d == 0) ? done0 : done1), 256'(m_done[d]));
        chk($sformatf("commit_forced[%0d]", d), 256'((d == 0) ? forced0 : forced1), 256'(m_forced[d]));
        chk($sformatf("commit_count[%0d]", d), 256'((d == 0) ? cnt0 : cnt1), 256'(m_cnt[d]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.wr_en = 0; bus.commit_req = 0; bus.abort_req = 0; trigger = 0;
  endtask

  task automatic wr(input int a, input int v);
    bus.wr_en = 1; bus.wr_addr = 4'(a); bus.wr_data = 16'(v);
    cyc();
  endtask

  task automatic commit();
    bus.commit_req = 1;
    cyc();
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.commit_req = 0; bus.abort_req = 0;
    repeat (3) cyc();
    reset = 0;
    repeat (2) cyc();
    chk("reset reg1", 256'(act0[1*16 +: 16]), 256'(60));
    chk("reset reg10", 256'(act0[10*16 +: 16]), 256'(342));
    chk("reset dirty", 256'(dirty0), 256'(0));
    chk("reset busy", 256'(busy0), 256'(0));
    chk("reset count", 256'(cnt0), 256'(0));

    // Synced commit waits for the trigger.
    synced = 1;
    wr(10, 400);
    commit();
    repeat (50) cyc();
    chk("armed reg10 held", 256'(act0[10*16 +: 16]), 256'(342));
    chk("armed busy", 256'(busy0), 256'(1));
    trigger = 1; cyc();
    chk("pre-commit reg10", 256'(act0[10*16 +: 16]), 256'(342));
    cyc();
    chk("trig reg10", 256'(act0[10*16 +: 16]), 256'(400));
    chk("trig done", 256'(done0), 256'(1));
    chk("trig forced", 256'(forced0), 256'(0));
    chk("trig count", 256'(cnt0), 256'(1));

    // Unsynced commit goes straight through.
    synced = 0;
    wr(12, 3000);
    commit();
    cyc();
    chk("unsync busy", 256'(busy0), 256'(1));
    chk("unsync reg12 held", 256'(act0[12*16 +: 16]), 256'(2000));
    cyc();
    chk("unsync reg12", 256'(act0[12*16 +: 16]), 256'(3000));
    chk("unsync count", 256'(cnt0), 256'(2));

    // Timeout on the small-timeout instance.
    synced = 1;
    wr(0, 16'h55);
    commit();
    repeat (8) cyc();
    chk("to not yet", 256'(done1), 256'(0));
    cyc();
    chk("to done", 256'(done1), 256'(1));
    chk("to forced", 256'(forced1), 256'(1));
    chk("to reg0", 256'(act1[15:0]), 256'(16'h55));
    chk("to dut0 still armed", 256'(busy0), 256'(1));
    trigger = 1; cyc(); cyc();
    chk("dut0 reg0", 256'(act0[15:0]), 256'(16'h55));

    // Abort beats trigger.
    wr(3, 9);
    commit();
    bus.abort_req = 1; trigger = 1; cyc();
    chk("abort busy", 256'(busy0), 256'(0));
    chk("abort dirty3", 256'(dirty0[3]), 256'(1));
    cyc();
    chk("abort reg3", 256'(act0[3*16 +: 16]), 256'(2));
    commit();
    trigger = 1; cyc(); cyc();
    chk("recommit reg3", 256'(act0[3*16 +: 16]), 256'(9));
    chk("recommit dirty", 256'(dirty0), 256'(0));

    // Write forwarded during the commit cycle.
    wr(5, 1);
    commit();
    trigger = 1; cyc();
    wr(11, 500);
    chk("fwd reg11", 256'(act0[11*16 +: 16]), 256'(500));
    chk("fwd dirty11", 256'(dirty0[11]), 256'(0));
    chk("fwd reg5", 256'(act0[5*16 +: 16]), 256'(1));

    // Commit with nothing dirty.
    commit();
    chk("empty done", 256'(done0), 256'(1));
    chk("empty busy", 256'(busy0), 256'(0));

    // Count wrap after 256 commits.
    reset = 1; cyc(); reset = 0; cyc();
    synced = 0;
    for (int k = 0; k < 256; k++) begin
      wr(k % 16, k);
      commit(); cyc(); cyc();
      if (k == 254) chk("count 255", 256'(cnt0), 256'(255));
    end
    chk("count wrap", 256'(cnt0), 256'(0));
    chk("count wrap dut1", 256'(cnt1), 256'(0));

    // Reset while armed.
    synced = 1;
    wr(7, 1);
    commit();
    reset = 1; cyc(); reset = 0;
    chk("rst armed reg7", 256'(act0[7*16 +: 16]), 256'(2560));
    chk("rst armed dirty", 256'(dirty0), 256'(0));
    chk("rst armed busy", 256'(busy0), 256'(0));

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      bus.wr_en      = ($urandom_range(0, 2) == 0);
      bus.wr_addr    = 4'($urandom_range(0, 15));
      bus.wr_data    = 16'($urandom);
      bus.commit_req = ($urandom_range(0, 5) == 0);
      bus.abort_req  = ($urandom_range(0, 15) == 0);
      trigger        = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 40) == 0) synced = ~synced;
      reset          = ($urandom_range(0, 600) == 0);
      @(posedge clk);
      #1;
    end
    reset = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
